cmd_sequencer: RTL and testbench

Upstream command stage for the calculator datapath (`BreadBoard`). Accepts `{opcode, operand}` commands through a valid/ready handshake and buffers them in a small FIFO. Drives the datapath's `OP`/`IN1` inputs with at most one command per clock, and inserts No-Op (`0000`) whenever nothing is pending. Monitors the datapath's `ERR` bits, keeps sticky error status, and optionally halts issue on an error.

---
 rtl/cmd_seq_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared constants for the calculator command sequencer: datapath opcodes,
// ERR bit positions and the issue-state encoding.
package cmd_seq_pkg;

  localparam int unsigned CNTW = 16;
  localparam int unsigned ERRW = 2;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_GND = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0110;
  localparam logic [3:0] OP_PRE = 4'b1110;
  localparam logic [3:0] OP_RES = 4'b1111;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_DZE = 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: read/write pointers carrying one extra wrap bit, synchronous
// flush, occupancy/full/empty derived from the pointer registers only.
module cmd_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  // Full and empty refuse the operation even if the caller asks for it.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer for the calculator datapath: buffers {opcode, operand}
// commands, issues one per clock, inserts No-Op when idle and latches ERR.
// Optional halt-on-error behaviour is enabled by defining CMD_SEQ_ERR_HALT_EN.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 4,
  parameter int unsigned DW    = 16,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [OPW-1:0]   CMD_OP,
  input  logic [DW-1:0]    CMD_DATA,
  input  logic             CLR,
  output logic [OPW-1:0]   OP,
  output logic [DW-1:0]    IN1,
  input  logic [ERRW-1:0]  ERR,
  output logic             BUSY,
  output logic             HALTED,
  output logic [ERRW-1:0]  ERR_LATCH,
  output logic [CNTW-1:0]  ISSUE_CNT,
  output logic [LW-1:0]    LEVEL
);

  localparam int unsigned CW = OPW + DW;

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic             do_pop;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    head;
  logic [LW-1:0]    fifo_level;

  logic [OPW-1:0]   op_q;
  logic [DW-1:0]    in1_q;
  logic             issued_q;
  logic [ERRW-1:0]  err_latch_q;
  logic [CNTW-1:0]  cnt_q;

  // CLR overrides a simultaneous push; READY itself depends on registers only.
  assign push = CMD_VALID & ~fifo_full & ~CLR;

  cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .flush (CLR),
    .push  (push),
    .wdata ({CMD_OP, CMD_DATA}),
    .pop   (do_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Issue decision; an error seen this edge stops the pop behind it.
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    case (state_q)
      RUN: begin
        do_pop = ~fifo_empty;
`ifdef CMD_SEQ_ERR_HALT_EN
        if (issued_q && (ERR[ERR_OVF] || ERR[ERR_DZE])) begin
          state_d = HALT;
          do_pop  = 1'b0;
        end
`endif
      end
      HALT: begin
        do_pop = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (CLR) begin
      state_d = RUN;
      do_pop  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q        <= '0;
      in1_q       <= '0;
      issued_q    <= 1'b0;
      err_latch_q <= '0;
      cnt_q       <= '0;
    end else if (CLR) begin
      op_q        <= OPW'(OP_NOP);
      in1_q       <= '0;
      issued_q    <= 1'b0;
      err_latch_q <= '0;
    end else begin
      if (issued_q) err_latch_q <= err_latch_q | ERR;
      if (do_pop) begin
        op_q     <= head[CW-1:DW];
        in1_q    <= head[DW-1:0];
        issued_q <= 1'b1;
        cnt_q    <= cnt_q + CNTW'(1);
      end else begin
        op_q     <= OPW'(OP_NOP);
        in1_q    <= '0;
        issued_q <= 1'b0;
      end
    end
  end

  assign OP        = op_q;
  assign IN1       = in1_q;
  assign ERR_LATCH = err_latch_q;
  assign ISSUE_CNT = cnt_q;
  assign LEVEL     = fifo_level;
  assign CMD_READY = ~fifo_full;
  assign BUSY      = ~fifo_empty | issued_q;

`ifdef CMD_SEQ_ERR_HALT_EN
  assign HALTED = (state_q == HALT);
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: queue-based command model checked every
// cycle, a small accumulator datapath stand-in driving ERR, and directed cases.
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
`ifdef CMD_SEQ_ERR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic [3:0]  CMD_OP = 4'h0;
  logic [15:0] CMD_DATA = 16'h0;
  logic        CLR = 1'b0;
  logic [1:0]  ERR;
  logic        CMD_READY;
  logic [3:0]  OP;
  logic [15:0] IN1;
  logic        BUSY;
  logic        HALTED;
  logic [1:0]  ERR_LATCH;
  logic [15:0] ISSUE_CNT;
  logic [LW-1:0] LEVEL;

  cmd_sequencer #(.DEPTH(DEPTH), .OPW(4), .DW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CLR(CLR), .OP(OP), .IN1(IN1),
    .ERR(ERR), .BUSY(BUSY), .HALTED(HALTED), .ERR_LATCH(ERR_LATCH),
    .ISSUE_CNT(ISSUE_CNT), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  // Datapath stand-in: returns {err, next accumulator}. Divide/mod take the
  // operand over the accumulator, so a zero accumulator is a divide by zero.
  function automatic logic [17:0] dp_step(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    logic [31:0] w;
    case (op)
      OP_NOP: return {2'b00, a};
      OP_ADD: begin w = 32'(a) + 32'(b); return {1'b0, w[16], w[15:0]}; end
      OP_SUB: begin w = 32'(a) - 32'(b); return {1'b0, (b > a), w[15:0]}; end
      OP_MUL: begin w = 32'(a) * 32'(b); return {1'b0, |w[31:16], w[15:0]}; end
      OP_DIV: if (a == 16'h0) return {2'b10, a}; else return {2'b00, b / a};
      OP_MOD: if (a == 16'h0) return {2'b10, a}; else return {2'b00, b % a};
      OP_PRE: return {2'b00, b};
      default: return {2'b00, 16'h0};
    endcase
  endfunction

  logic [15:0] acc;
  logic [17:0] dp_nxt;
  logic        force_en = 1'b0;
  logic [1:0]  force_err = 2'b00;

  assign dp_nxt = dp_step(OP, acc, IN1);
  assign ERR    = force_en ? force_err : dp_nxt[17:16];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) acc <= 16'h0;
    else        acc <= dp_nxt[15:0];
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] d;
  } cmd_t;

  cmd_t        mq[$];
  logic [3:0]  m_op;
  logic [15:0] m_in1;
  logic [15:0] m_cnt;
  logic        m_issued;
  logic        m_halt;
  logic [1:0]  m_errl;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_op = 4'h0; m_in1 = 16'h0; m_cnt = 16'h0;
    m_issued = 1'b0; m_halt = 1'b0; m_errl = 2'b00;
  endtask

  // One clock edge of the sequencer, from the inputs seen at that edge.
  task automatic model_step(input logic v, input logic [3:0] o, input logic [15:0] d,
                            input logic c, input logic [1:0] e);
    int   pre_n;
    logic stop;
    cmd_t cm;
    if (c) begin
      mq.delete();
      m_op = 4'h0; m_in1 = 16'h0; m_issued = 1'b0; m_errl = 2'b00; m_halt = 1'b0;
      return;
    end
    stop  = m_halt || (HALT_EN && m_issued && (e != 2'b00));
    if (m_issued) m_errl = m_errl | e;
    pre_n = mq.size();
    if (!stop && pre_n > 0) begin
      cm = mq.pop_front();
      m_op = cm.op; m_in1 = cm.d; m_issued = 1'b1; m_cnt = m_cnt + 16'd1;
    end else begin
      m_op = 4'h0; m_in1 = 16'h0; m_issued = 1'b0;
    end
    if (v && pre_n < int'(DEPTH)) begin
      cm.op = o; cm.d = d;
      mq.push_back(cm);
    end
    m_halt = stop;
  endtask

  task automatic compare_all();
    if (!chk_on) return;
    chk("op", 32'(OP), 32'(m_op));
    chk("in1", 32'(IN1), 32'(m_in1));
    chk("issue_cnt", 32'(ISSUE_CNT), 32'(m_cnt));
    chk("err_latch", 32'(ERR_LATCH), 32'(m_errl));
    chk("halted", 32'(HALTED), 32'(m_halt));
    chk("level", 32'(LEVEL), 32'(mq.size()));
    chk("ready", 32'(CMD_READY), 32'(mq.size() < int'(DEPTH)));
    chk("busy", 32'(BUSY), 32'((mq.size() != 0) || m_issued));
  endtask

  task automatic step_edge();
    logic v, c;
    logic [3:0] o;
    logic [15:0] d;
    logic [1:0] e;
    @(posedge CLK);
    v = CMD_VALID; o = CMD_OP; d = CMD_DATA; c = CLR; e = ERR;
    #1;
    if (!RST_N) model_reset();
    else        model_step(v, o, d, c, e);
  endtask

  task automatic tick();
    step_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [15:0] d);
    CMD_VALID = v; CMD_OP = o; CMD_DATA = d;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_op"}, 32'(OP), 0);
    chk({tag, "_in1"}, 32'(IN1), 0);
    chk({tag, "_ready"}, 32'(CMD_READY), 1);
    chk({tag, "_level"}, 32'(LEVEL), 0);
    chk({tag, "_cnt"}, 32'(ISSUE_CNT), 0);
    chk({tag, "_halted"}, 32'(HALTED), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_errl"}, 32'(ERR_LATCH), 0);
  endtask

  logic [3:0]  s_op [4];
  logic [15:0] s_d  [4];
  logic [15:0] seen [7];

  initial begin
    model_reset();
    repeat (2) tick();
    RST_N  = 1'b1;
    chk_on = 1'b1;
    chk_reset_values("reset");

    // Preload accumulator so the RES in the stream visibly clears it.
    drive(1'b1, OP_PRE, 16'd99);
    tick();
    drive(1'b0, OP_NOP, 16'd0);
    repeat (2) tick();
    chk("preset_acc", 32'(acc), 99);

    // Back-to-back stream: results land at edges k+2..k+5.
    s_op[0] = OP_RES; s_d[0] = 16'd0;
    s_op[1] = OP_ADD; s_d[1] = 16'd10;
    s_op[2] = OP_MUL; s_d[2] = 16'd15;
    s_op[3] = OP_SUB; s_d[3] = 16'd50;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_op[i], s_d[i]);
      tick();
      seen[i] = acc;
    end
    drive(1'b0, OP_NOP, 16'd0);
    for (int i = 4; i < 7; i++) begin
      tick();
      seen[i] = acc;
    end
    chk("stream_acc_k2", 32'(seen[2]), 0);
    chk("stream_acc_k3", 32'(seen[3]), 10);
    chk("stream_acc_k4", 32'(seen[4]), 150);
    chk("stream_acc_k5", 32'(seen[5]), 100);
    chk("stream_cnt", 32'(ISSUE_CNT), 5);
    chk("stream_op_idle", 32'(OP), 0);

    // Divide by zero with an ADD queued behind it.
    drive(1'b1, OP_RES, 16'd0);  tick();
    drive(1'b1, OP_DIV, 16'd7);  tick();
    drive(1'b1, OP_ADD, 16'd1);  tick();
    drive(1'b0, OP_NOP, 16'd0);  tick();
    chk("dze_errl", 32'(ERR_LATCH), 2);
`ifdef CMD_SEQ_ERR_HALT_EN
    chk("dze_halted", 32'(HALTED), 1);
    chk("dze_level", 32'(LEVEL), 1);
    chk("dze_op_nop", 32'(OP), 0);
    tick();
    chk("dze_add_held", 32'(ISSUE_CNT), 7);
    chk("dze_op_still_nop", 32'(OP), 0);
`else
    chk("dze_halted", 32'(HALTED), 0);
    chk("dze_op_add", 32'(OP), 32'(OP_ADD));
    chk("dze_in1", 32'(IN1), 1);
    tick();
    chk("dze_add_cnt", 32'(ISSUE_CNT), 8);
    chk("dze_add_acc", 32'(acc), 1);
`endif

    // Clear with a push offered in the same cycle.
`ifdef CMD_SEQ_ERR_HALT_EN
    drive(1'b1, OP_ADD, 16'd2); tick();
    drive(1'b1, OP_ADD, 16'd3); tick();
    chk("clr_pre_level", 32'(LEVEL), 3);
`endif
    drive(1'b1, OP_ADD, 16'd4);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    drive(1'b0, OP_NOP, 16'd0);
    chk("clr_level", 32'(LEVEL), 0);
    chk("clr_errl", 32'(ERR_LATCH), 0);
    chk("clr_halted", 32'(HALTED), 0);
    tick();
    chk("clr_push_dropped", 32'(LEVEL), 0);
    chk("clr_cnt", 32'(ISSUE_CNT), HALT_EN ? 7 : 8);

    // Sticky overflow; with halt enabled, then fill the FIFO past full.
    force_err = 2'b01;
    force_en  = 1'b1;
    drive(1'b1, OP_ADD, 16'd0); tick();
    drive(1'b0, OP_NOP, 16'd0); tick();
    tick();
    chk("ovf_errl", 32'(ERR_LATCH), 1);
`ifdef CMD_SEQ_ERR_HALT_EN
    chk("ovf_halted", 32'(HALTED), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_ADD, 16'(i + 20));
      tick();
      if (i == 3) chk("full_ready_after4", 32'(CMD_READY), 0);
    end
    chk("full_level", 32'(LEVEL), 4);
    chk("full_ready", 32'(CMD_READY), 0);
`else
    chk("ovf_halted", 32'(HALTED), 0);
    chk("ovf_level", 32'(LEVEL), 0);
`endif
    drive(1'b0, OP_NOP, 16'd0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    force_en = 1'b0;
    tick();
    chk("post_clr_level", 32'(LEVEL), 0);
    chk("post_clr_halted", 32'(HALTED), 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 16'(i + 1));
      tick();
    end
    step_edge();
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk_reset_values("async");
    repeat (2) tick();
    RST_N = 1'b1;
    drive(1'b0, OP_NOP, 16'd0);
    repeat (3) tick();
    chk("after_rst_op", 32'(OP), 0);
    chk("after_rst_cnt", 32'(ISSUE_CNT), 0);
    chk("after_rst_level", 32'(LEVEL), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
